// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Fills instruction memory from a length/data/checksum byte frame
//            and holds the core in reset until the image is verified.
// Revision : 1.0
// ============================================================================
module imem_boot_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam logic [31:0] c_max_words = MAX_WORDS;

    typedef enum logic [2:0] {
        S_LEN0  = 3'd0,
        S_LEN1  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rx_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_core_reset;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [15:0]       r_words;
    logic [15:0]       r_len;
    logic [31:0]       r_asm;
    logic [7:0]        r_csum;
    logic [1:0]        r_bcnt;
    logic              w_accept;
    logic [15:0]       w_len_full;
    logic [ADDR_W-1:0] w_word_addr;

    assign w_accept    = rx_valid & r_rx_ready;
    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_word_addr = BASE_ADDR + ADDR_W'({r_words, 2'b00});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_LEN0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN0: if (w_accept) w_next = S_LEN1;
            S_LEN1: begin
                if (w_accept) begin
                    if (w_len_full == 16'd0)                       w_next = S_CSUM;
                    else if ({16'd0, w_len_full} > c_max_words)    w_next = S_ERROR;
                    else                                           w_next = S_DATA;
                end
            end
            S_DATA:  if (w_accept && r_bcnt == 2'd3) w_next = S_WRITE;
            S_WRITE: w_next = (r_words + 16'd1 == r_len) ? S_CSUM : S_DATA;
            S_CSUM: begin
                if (w_accept) w_next = (rx_data == r_csum) ? S_DONE : S_ERROR;
            end
            S_DONE:  if (start) w_next = S_LEN0;
            S_ERROR: if (start) w_next = S_LEN0;
            default: w_next = S_LEN0;
        endcase
    end

    // Status outputs are registered decodes of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_ready   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_wdata      <= 32'd0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_words      <= 16'd0;
            r_len        <= 16'd0;
            r_asm        <= 32'd0;
            r_csum       <= 8'd0;
            r_bcnt       <= 2'd0;
        end else begin
            r_rx_ready   <= (w_next == S_LEN0) || (w_next == S_LEN1) ||
                            (w_next == S_DATA) || (w_next == S_CSUM);
            r_busy       <= (w_next == S_LEN0) || (w_next == S_LEN1) ||
                            (w_next == S_DATA) || (w_next == S_WRITE) ||
                            (w_next == S_CSUM);
            r_done       <= (w_next == S_DONE);
            r_error      <= (w_next == S_ERROR);
            r_core_reset <= (w_next != S_DONE);
            r_we         <= (w_next == S_WRITE);
            case (r_state)
                S_LEN0: if (w_accept) r_len[7:0]  <= rx_data;
                S_LEN1: if (w_accept) r_len[15:8] <= rx_data;
                S_DATA: begin
                    if (w_accept) begin
                        r_asm  <= {rx_data, r_asm[31:8]};
                        r_csum <= r_csum ^ rx_data;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_wdata <= {rx_data, r_asm[31:8]};
                            r_addr  <= w_word_addr;
                        end
                    end
                end
                S_WRITE: r_words <= r_words + 16'd1;
                S_DONE, S_ERROR: begin
                    if (start) begin
                        r_words <= 16'd0;
                        r_csum  <= 8'd0;
                        r_asm   <= 32'd0;
                        r_bcnt  <= 2'd0;
                        r_len   <= 16'd0;
                        r_addr  <= BASE_ADDR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_ready     = r_rx_ready;
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign core_reset   = r_core_reset;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Directed and randomized frames against a frame-level model;
//            two loader instances (base 0x0 and 0x100) share one stimulus.
// Revision : 1.0
// ============================================================================
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready0, we0, core_reset0, busy0, done0, error0;
    logic        rx_ready1, we1, core_reset1, busy1, done1, error1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [15:0] words0, words1;

    imem_boot_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(256)) u_dut0 (
        .clk(clk), .reset(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
        .core_reset(core_reset0), .busy(busy0), .done(done0), .error(error0),
        .words_loaded(words0));

    imem_boot_loader #(.ADDR_W(32), .BASE_ADDR(32'h100), .MAX_WORDS(256)) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
        .core_reset(core_reset1), .busy(busy1), .done(done1), .error(error1),
        .words_loaded(words1));

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int wcount0     = 0;
    int wcount1     = 0;
    int wexp        = 0;

    always @(negedge clk) begin
        if (we0) wcount0++;
        if (we1) wcount1++;
    end

    logic [7:0]  frame[$];
    logic [31:0] m_data[$];
    int          m_accept, m_n;
    bit          m_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level view: how many bytes the loader consumes, what it writes, how it ends.
    function automatic void model();
        int          n;
        logic [7:0]  x;
        m_data.delete();
        n = {frame[1], frame[0]};
        x = 8'h00;
        if (n > 256) begin
            m_accept = 2; m_n = 0; m_ok = 1'b0;
        end else begin
            m_n = n;
            m_accept = 2 + 4 * n + 1;
            for (int w = 0; w < n; w++) begin
                m_data.push_back({frame[2+4*w+3], frame[2+4*w+2], frame[2+4*w+1], frame[2+4*w]});
                for (int k = 0; k < 4; k++) x = x ^ frame[2+4*w+k];
            end
            m_ok = (frame[2+4*n] == x);
        end
    endfunction

    function automatic logic [7:0] xor_data(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x = x ^ frame[2+i];
        return x;
    endfunction

    task automatic xfer(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 64 && !ok; t++) begin
            if (rx_ready0 === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("xfer_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic run_frame(input int maxgap, input int limit);
        int w;
        int nb;
        model();
        nb = (limit < m_accept) ? limit : m_accept;
        for (int i = 0; i < nb; i++) begin
            xfer(frame[i], (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
            if (i >= 2 && i < 2 + 4 * m_n && ((i - 2) % 4) == 3) begin
                w = (i - 2) / 4;
                wexp++;
                chk("we0", {31'd0, we0}, 32'd1);
                chk("we1", {31'd0, we1}, 32'd1);
                chk("addr0", addr0, 32'(4 * w));
                chk("addr1", addr1, 32'h100 + 32'(4 * w));
                chk("wdata0", wdata0, m_data[w]);
                chk("wdata1", wdata1, m_data[w]);
                chk("rdy_in_write", {31'd0, rx_ready0}, 32'd0);
            end else begin
                chk("we_idle", {30'd0, we0, we1}, 32'd0);
            end
        end
        if (nb == m_accept) begin
            chk("done0", {31'd0, done0}, {31'd0, m_ok});
            chk("done1", {31'd0, done1}, {31'd0, m_ok});
            chk("error0", {31'd0, error0}, {31'd0, !m_ok});
            chk("core_reset0", {31'd0, core_reset0}, {31'd0, !m_ok});
            chk("core_reset1", {31'd0, core_reset1}, {31'd0, !m_ok});
            chk("words0", {16'd0, words0}, 32'(m_n));
            chk("busy0", {31'd0, busy0}, 32'd0);
            chk("rdy_end", {31'd0, rx_ready0}, 32'd0);
            chk("wcount0", 32'(wcount0), 32'(wexp));
            chk("wcount1", 32'(wcount1), 32'(wexp));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("arm_ready", {31'd0, rx_ready0}, 32'd1);
        chk("arm_busy", {31'd0, busy0}, 32'd1);
        chk("arm_words", {16'd0, words0}, 32'd0);
        chk("arm_core_reset", {31'd0, core_reset0}, 32'd1);
        chk("arm_flags", {30'd0, done0, error0}, 32'd0);
        chk("arm_addr0", addr0, 32'h0);
        chk("arm_addr1", addr1, 32'h100);
    endtask

    task automatic check_reset_values();
        chk("rst_ready", {31'd0, rx_ready0}, 32'd0);
        chk("rst_we", {30'd0, we0, we1}, 32'd0);
        chk("rst_addr0", addr0, 32'h0);
        chk("rst_addr1", addr1, 32'h100);
        chk("rst_wdata", wdata0, 32'h0);
        chk("rst_core_reset", {31'd0, core_reset0}, 32'd1);
        chk("rst_flags", {29'd0, busy0, done0, error0}, 32'd0);
        chk("rst_words", {16'd0, words0}, 32'd0);
    endtask

    task automatic load_frame1(input logic [7:0] csum);
        frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h00};
        frame[10] = csum;
    endtask

    task automatic load_random(input int n, input bit good);
        frame.delete();
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
        frame.push_back(good ? xor_data(n) : (xor_data(n) ^ 8'(1 + $urandom_range(254, 0))));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        chk("ready_before_edge", {31'd0, rx_ready0}, 32'd0);
        @(negedge clk);
        chk("ready_after_release", {31'd0, rx_ready0}, 32'd1);

        // Scenario 1: good two-word image; known word values.
        load_frame1(8'h00);
        frame[10] = xor_data(2);
        run_frame(0, 1000);
        chk("s1_word0", m_data[0], 32'h00500013);
        chk("s1_word1", m_data[1], 32'h00A00093);

        // Scenario 2: bad checksum, then re-arm.
        pulse_start();
        load_frame1(8'h00);
        run_frame(0, 1000);
        pulse_start();

        // Scenario 3: empty image, then oversize length.
        frame = '{8'h00, 8'h00, 8'h00};
        run_frame(0, 1000);
        pulse_start();
        frame = '{8'h01, 8'h01};
        run_frame(0, 1000);
        pulse_start();

        // Scenario 4: gapped replays and random frames, including the size limit.
        for (int r = 0; r < 3; r++) begin
            load_frame1(8'h00);
            frame[10] = xor_data(2);
            run_frame(5, 1000);
            pulse_start();
        end
        for (int r = 0; r < 6; r++) begin
            load_random(int'($urandom_range(8, 1)), ($urandom_range(3, 0) != 0));
            run_frame(int'($urandom_range(5, 0)), 1000);
            pulse_start();
        end
        load_random(256, 1'b1);
        run_frame(0, 2000);
        pulse_start();

        // Scenario 5: asynchronous reset with a partial second word in flight.
        load_frame1(8'h00);
        frame[10] = xor_data(2);
        run_frame(0, 7);
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        repeat (3) @(negedge clk);
        chk("rst_no_write", 32'(wcount0), 32'(wexp));
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(2, 1000);

        // Scenario 6: bytes offered after DONE are refused.
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_done_ready", {31'd0, rx_ready0}, 32'd0);
            chk("post_done_state", {29'd0, done0, we0, busy0}, 32'd4);
        end
        rx_valid = 1'b0;
        chk("post_done_words", {16'd0, words1}, 32'd2);
        chk("post_done_wcount", 32'(wcount1), 32'(wexp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
